// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcodes, R-type funct codes, ALU op classes and ALU control codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop class (and funct for R-type) to the
// 3-bit ALU function code. Purely combinational.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB:   o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default:     o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: Moore main FSM driving datapath enables
// and selects, plus the Mealy branch term that forms pcen from zero.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  statetype   r_state, w_next;
  logic       w_pcwrite, w_branch, w_bne;
  logic [1:0] w_aluop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_BNE:       w_next = BNEEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   w_next = MEMWB;
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    w_bne     = 1'b0;
    w_aluop   = ALUOP_ADD;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    if (reset) begin
      // Present the FETCH datapath selects but keep every write enable low.
      alusrcb = 2'b01;
    end else begin
      case (r_state)
        FETCH: begin
          alusrcb   = 2'b01;
          irwrite   = 1'b1;
          w_pcwrite = 1'b1;
        end
        DECODE:  alusrcb = 2'b11;
        MEMADR, ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD:   iord = 1'b1;
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          w_aluop = ALUOP_FUNCT;
        end
        RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        ADDIWB:  regwrite = 1'b1;
        BEQEX, BNEEX: begin
          alusrca  = 1'b1;
          w_aluop  = ALUOP_SUB;
          pcsrc    = 2'b01;
          w_branch = (r_state == BEQEX);
          w_bne    = (r_state == BNEEX);
        end
        JEX: begin
          pcsrc     = 2'b10;
          w_pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pcen  = w_pcwrite | (w_branch & zero) | (w_bne & ~zero);
  assign state = r_state;

  mc_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

endmodule
